// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared types for the NoC link receive path.
//   rx_frame_state_t : packet-framing FSM state (EXPECT_HEAD, IN_BODY)
//   noc_flit_t       : packed flit {data, dest, user, is_tail}
//   FLIT_W/DEST_W/USER_W : default field widths
// ---------------------------------------------------------------------------
package noc_pkg;

    localparam int FLIT_W = 128;
    localparam int DEST_W = 8;
    localparam int USER_W = 32;

    typedef enum logic {
        EXPECT_HEAD = 1'b0,
        IN_BODY     = 1'b1
    } rx_frame_state_t;

    typedef struct packed {
        logic [FLIT_W-1:0] data;
        logic [DEST_W-1:0] dest;
        logic [USER_W-1:0] user;
        logic              is_tail;
    } noc_flit_t;

    localparam int FLIT_ENTRY_W = $bits(noc_flit_t);

endpackage

// File: rtl/noc_flit_fifo.sv
// ---------------------------------------------------------------------------
// noc_flit_fifo
// Show-ahead FIFO of DEPTH entries of WIDTH bits. DEPTH need not be a power
// of two; full/empty come from the entry count, not pointer equality.
// Ports:
//   clk, rst_n      : clock, async active-low reset (pointers/count only)
//   i_push, i_wdata : write request; ignored while full
//   i_pop           : read request; ignored while empty
//   o_rdata         : entry at the read pointer (unmasked)
//   o_full, o_empty : derived from count
//   o_count         : registered entry count
// ---------------------------------------------------------------------------
module noc_flit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_wdata,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr];
    assign o_count   = r_count;

    // Payload storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= (r_wptr == PTR_W'(DEPTH-1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= (r_rptr == PTR_W'(DEPTH-1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/noc_link_rx_buffer.sv
// ---------------------------------------------------------------------------
// noc_link_rx_buffer
// Credit-based receive buffer at the far end of a NoC link. Captures every
// flit sent on the link, presents it show-ahead with valid/ready, returns one
// registered credit pulse per pop, marks packet heads, flags overflow.
// Handshake: a flit transfers on a rising edge where valid_out && ready_in;
// valid_out does not depend on ready_in.
// Ports:
//   data_in/dest_in/user_in/is_tail_in/send_in : link side input
//   credit_out  : one-cycle credit pulse, one cycle after each pop
//   data_out/dest_out/user_out/is_tail_out/is_head_out : head flit, 0 when
//                 valid_out is low
//   valid_out/ready_in : consumer handshake
//   occupancy   : registered entry count
//   overflow_err: sticky, set when a flit arrives while full
// ---------------------------------------------------------------------------
module noc_link_rx_buffer
    import noc_pkg::*;
#(
    parameter int BUFFER_DEPTH = 4,
    parameter int FLIT_WIDTH   = FLIT_W,
    parameter int USER_WIDTH   = USER_W,
    parameter int DEST_WIDTH   = DEST_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [FLIT_WIDTH-1:0]               data_in,
    input  logic [DEST_WIDTH-1:0]               dest_in,
    input  logic [USER_WIDTH-1:0]               user_in,
    input  logic                                is_tail_in,
    input  logic                                send_in,
    output logic                                credit_out,
    output logic [FLIT_WIDTH-1:0]               data_out,
    output logic [DEST_WIDTH-1:0]               dest_out,
    output logic [USER_WIDTH-1:0]               user_out,
    output logic                                is_tail_out,
    output logic                                is_head_out,
    output logic                                valid_out,
    input  logic                                ready_in,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0]   occupancy,
    output logic                                overflow_err
);

    localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               r_credit;
    logic               r_overflow;

    rx_frame_state_t    r_frame_state;
    rx_frame_state_t    w_frame_next;

    // Entry layout matches noc_flit_t: {data, dest, user, is_tail}.
    assign w_wdata = {data_in, dest_in, user_in, is_tail_in};
    assign w_pop   = !w_empty && ready_in;

    noc_flit_fifo #(
        .DEPTH (BUFFER_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (send_in),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (occupancy)
    );

    // Fullness is judged on the pre-edge count, so a push while full is
    // dropped and flagged even when a pop happens in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit      <= 1'b0;
            r_overflow    <= 1'b0;
            r_frame_state <= EXPECT_HEAD;
        end else begin
            r_credit      <= w_pop;
            r_frame_state <= w_frame_next;
            if (send_in && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_frame_next = r_frame_state;
        if (w_pop) begin
            // A popped tail always closes the packet; a non-tail opens or
            // continues a body.
            w_frame_next = w_rdata[0] ? EXPECT_HEAD : IN_BODY;
        end
    end

    assign valid_out    = !w_empty;
    assign credit_out   = r_credit;
    assign overflow_err = r_overflow;

    assign data_out    = valid_out ? w_rdata[ENTRY_W-1 -: FLIT_WIDTH] : '0;
    assign dest_out    = valid_out ? w_rdata[USER_WIDTH+DEST_WIDTH : USER_WIDTH+1] : '0;
    assign user_out    = valid_out ? w_rdata[USER_WIDTH:1] : '0;
    assign is_tail_out = valid_out && w_rdata[0];
    assign is_head_out = valid_out && (r_frame_state == EXPECT_HEAD);

endmodule
